// File: rtl/weight_loader_pkg.sv
// Shared types and helpers for the double-buffered weight loader.
package weight_loader_pkg;

  localparam int DEF_ELEM_WIDTH = 8;
  localparam int DEF_MAX_R      = 5;
  localparam int DEF_MAX_S      = 5;
  localparam int DEF_ROW_W      = DEF_MAX_S * DEF_ELEM_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  typedef logic [DEF_ROW_W-1:0] row_t;

  // A filter dimension is usable when it is non-zero and fits in the bank.
  function automatic logic dim_in_range(input logic [3:0] dim, input int unsigned max_dim);
    return (dim != 4'd0) && (32'(dim) <= max_dim);
  endfunction

endpackage

// File: rtl/weight_pingpong_loader_fifo.sv
// First-word-fall-through FIFO with a synchronous flush; RD_DATA shows the head word whenever EMPTY is low.
module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             FLUSH,
  input  logic             WR_EN,
  input  logic [WIDTH-1:0] WR_DATA,
  input  logic             RD_EN,
  output logic [WIDTH-1:0] RD_DATA,
  output logic             FULL,
  output logic             EMPTY
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_wr;
  logic             do_rd;

  assign EMPTY   = (wr_ptr == rd_ptr);
  assign FULL    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr   = WR_EN & ~FULL & ~FLUSH;
  assign do_rd   = RD_EN & ~EMPTY & ~FLUSH;
  assign RD_DATA = mem[rd_ptr[AW-1:0]];

  // Pointers carry one wrap bit so full and empty can be told apart; flush wins over push/pop.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (FLUSH) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array; contents need no reset because EMPTY guards every read.
  always_ff @(posedge CLK) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= WR_DATA;
  end

endmodule

// File: rtl/weight_pingpong_loader.sv
// Double-buffered weight loader: fills the shadow bank from a FIFO while the MAC array reads the active bank.
module weight_pingpong_loader
  import weight_loader_pkg::*;
#(
  parameter int INPUT_WIDTH = 32,
  parameter int ELEM_WIDTH  = DEF_ELEM_WIDTH,
  parameter int MAX_R       = DEF_MAX_R,
  parameter int MAX_S       = DEF_MAX_S,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                           CLK,
  input  logic                           RESETN,
  input  logic                           CLEAR,
  input  logic                           FIFO_WR_CMD,
  input  logic [INPUT_WIDTH-1:0]         FIFO_WR_DATA,
  output logic                           FIFO_FULL,
  output logic                           FIFO_EMPTY,
  input  logic [3:0]                     PARAM_R,
  input  logic [3:0]                     PARAM_S,
  input  logic                           LOAD_START,
  input  logic                           SWAP,
  output logic                           LOAD_BUSY,
  output logic                           LOAD_ERR,
  output logic                           SHADOW_READY,
  output logic                           ACTIVE_VALID,
  output logic                           ACTIVE_BANK,
  output logic [3:0]                     ACTIVE_R,
  output logic [3:0]                     ACTIVE_S,
  output logic [MAX_R*MAX_S*ELEM_WIDTH-1:0] WS_RD_DATA
);

  localparam int ROW_W = MAX_S * ELEM_WIDTH;
  localparam int RW    = (MAX_R > 1) ? $clog2(MAX_R) : 1;
  localparam int CW    = (MAX_S > 1) ? $clog2(MAX_S) : 1;

  state_t                  state;
  state_t                  state_next;
  logic                    load_start_q;
  logic                    load_req;
  logic                    swap_take;
  logic                    load_accept;
  logic                    load_reject;
  logic                    pop;
  logic                    last_write;
  logic                    shadow_sel;
  logic                    shadow_ready_q;
  logic                    active_bank_q;
  logic                    active_valid_q;
  logic                    load_err_q;
  logic [3:0]              active_r_q;
  logic [3:0]              active_s_q;
  logic [3:0]              r_lat;
  logic [3:0]              s_lat;
  logic [RW-1:0]           row_cnt;
  logic [CW-1:0]           col_cnt;
  logic                    col_last;
  logic                    row_last;
  logic [INPUT_WIDTH-1:0]  fifo_rd_data;
  logic                    fifo_empty;
  logic [ROW_W-1:0]        bank [2][MAX_R];

  fifo #(
    .WIDTH (INPUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .FLUSH   (CLEAR),
    .WR_EN   (FIFO_WR_CMD),
    .WR_DATA (FIFO_WR_DATA),
    .RD_EN   (pop),
    .RD_DATA (fifo_rd_data),
    .FULL    (FIFO_FULL),
    .EMPTY   (fifo_empty)
  );

  assign FIFO_EMPTY   = fifo_empty;
  assign LOAD_BUSY    = (state == LOAD);
  assign LOAD_ERR     = load_err_q;
  assign SHADOW_READY = shadow_ready_q;
  assign ACTIVE_VALID = active_valid_q;
  assign ACTIVE_BANK  = active_bank_q;
  assign ACTIVE_R     = active_r_q;
  assign ACTIVE_S     = active_s_q;
  assign col_last     = (4'(col_cnt) == s_lat - 4'd1);
  assign row_last     = (4'(row_cnt) == r_lat - 4'd1);

  // State register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_next;
  end

  // Next state and per-cycle controls; a same-cycle swap is applied before judging a load request.
  always_comb begin
    state_next  = state;
    load_accept = 1'b0;
    load_reject = 1'b0;
    pop         = 1'b0;
    last_write  = 1'b0;
    load_req    = LOAD_START & ~load_start_q;
    swap_take   = SWAP & shadow_ready_q;
    shadow_sel  = swap_take ? active_bank_q : ~active_bank_q;
    case (state)
      IDLE: begin
        if (!CLEAR && load_req) begin
          if (!(shadow_ready_q && !swap_take) &&
              dim_in_range(PARAM_R, MAX_R) && dim_in_range(PARAM_S, MAX_S)) begin
            load_accept = 1'b1;
            state_next  = LOAD;
          end else begin
            load_reject = 1'b1;
          end
        end
      end
      LOAD: begin
        if (CLEAR) begin
          state_next = IDLE;
        end else begin
          load_reject = load_req;
          if (!fifo_empty) begin
            pop = 1'b1;
            if (row_last && col_last) begin
              last_write = 1'b1;
              state_next = IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Edge detect, error pulse, swap bookkeeping, latched dimensions and the write cursor.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      load_start_q   <= 1'b0;
      load_err_q     <= 1'b0;
      shadow_ready_q <= 1'b0;
      active_bank_q  <= 1'b0;
      active_valid_q <= 1'b0;
      active_r_q     <= '0;
      active_s_q     <= '0;
      r_lat          <= '0;
      s_lat          <= '0;
      row_cnt        <= '0;
      col_cnt        <= '0;
    end else begin
      load_start_q <= LOAD_START;
      load_err_q   <= load_reject;
      if (swap_take) begin
        active_bank_q  <= ~active_bank_q;
        active_r_q     <= r_lat;
        active_s_q     <= s_lat;
        active_valid_q <= 1'b1;
      end
      if (CLEAR || swap_take) shadow_ready_q <= 1'b0;
      else if (last_write)    shadow_ready_q <= 1'b1;
      if (load_accept) begin
        r_lat   <= PARAM_R;
        s_lat   <= PARAM_S;
        row_cnt <= '0;
        col_cnt <= '0;
      end else if (pop) begin
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

  // Bank storage: the shadow bank is cleared when a load starts, then filled one weight per pop.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < MAX_R; r++)
          bank[b][r] <= '0;
    end else if (load_accept) begin
      for (int r = 0; r < MAX_R; r++)
        bank[shadow_sel][r] <= '0;
    end else if (pop) begin
      bank[~active_bank_q][row_cnt][int'(col_cnt)*ELEM_WIDTH +: ELEM_WIDTH] <= fifo_rd_data[ELEM_WIDTH-1:0];
    end
  end

  // Present the active bank as one flat word, row 0 in the least significant slot.
  always_comb begin
    WS_RD_DATA = '0;
    for (int r = 0; r < MAX_R; r++)
      WS_RD_DATA[r*ROW_W +: ROW_W] = bank[active_bank_q][r];
  end

endmodule

// File: tb/tb_weight_pingpong_loader.sv
// Directed self-checking bench for weight_pingpong_loader.
module tb_weight_pingpong_loader;

  localparam int WS_W  = 200;
  localparam int ROW_W = 40;

  logic             CLK;
  logic             RESETN;
  logic             CLEAR;
  logic             FIFO_WR_CMD;
  logic [31:0]      FIFO_WR_DATA;
  logic             FIFO_FULL;
  logic             FIFO_EMPTY;
  logic [3:0]       PARAM_R;
  logic [3:0]       PARAM_S;
  logic             LOAD_START;
  logic             SWAP;
  logic             LOAD_BUSY;
  logic             LOAD_ERR;
  logic             SHADOW_READY;
  logic             ACTIVE_VALID;
  logic             ACTIVE_BANK;
  logic [3:0]       ACTIVE_R;
  logic [3:0]       ACTIVE_S;
  logic [WS_W-1:0]  WS_RD_DATA;

  int               compare_count;
  int               fail_count;
  int               busy_cycles;
  logic [WS_W-1:0]  exp_first;
  logic [WS_W-1:0]  exp_a;
  logic [WS_W-1:0]  exp_b;
  logic [31:0]      trickle [4];

  weight_pingpong_loader dut (
    .CLK          (CLK),
    .RESETN       (RESETN),
    .CLEAR        (CLEAR),
    .FIFO_WR_CMD  (FIFO_WR_CMD),
    .FIFO_WR_DATA (FIFO_WR_DATA),
    .FIFO_FULL    (FIFO_FULL),
    .FIFO_EMPTY   (FIFO_EMPTY),
    .PARAM_R      (PARAM_R),
    .PARAM_S      (PARAM_S),
    .LOAD_START   (LOAD_START),
    .SWAP         (SWAP),
    .LOAD_BUSY    (LOAD_BUSY),
    .LOAD_ERR     (LOAD_ERR),
    .SHADOW_READY (SHADOW_READY),
    .ACTIVE_VALID (ACTIVE_VALID),
    .ACTIVE_BANK  (ACTIVE_BANK),
    .ACTIVE_R     (ACTIVE_R),
    .ACTIVE_S     (ACTIVE_S),
    .WS_RD_DATA   (WS_RD_DATA)
  );

  // Free-running 10 ns clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [WS_W-1:0] observed, input logic [WS_W-1:0] expected);
    compare_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic push_word(input logic [31:0] data);
    FIFO_WR_DATA = data;
    FIFO_WR_CMD  = 1'b1;
    tick();
    FIFO_WR_CMD  = 1'b0;
  endtask

  task automatic pulse_load(input logic [3:0] r, input logic [3:0] s);
    PARAM_R    = r;
    PARAM_S    = s;
    LOAD_START = 1'b1;
    tick();
    LOAD_START = 1'b0;
  endtask

  task automatic do_swap();
    SWAP = 1'b1;
    tick();
    SWAP = 1'b0;
  endtask

  task automatic wait_ready(output int busy);
    busy = 0;
    for (int i = 0; i < 200; i++) begin
      if (SHADOW_READY) break;
      if (LOAD_BUSY) busy++;
      tick();
    end
  endtask

  // Directed sequence of stimulus and checks.
  initial begin
    compare_count = 0;
    fail_count    = 0;
    RESETN        = 1'b0;
    CLEAR         = 1'b0;
    FIFO_WR_CMD   = 1'b0;
    FIFO_WR_DATA  = '0;
    PARAM_R       = '0;
    PARAM_S       = '0;
    LOAD_START    = 1'b0;
    SWAP          = 1'b0;

    exp_first = {40'h0, 40'h0, 40'h0000090807, 40'h0000060504, 40'h0000030201};
    exp_b     = {120'h0, 40'h0000004433, 40'h0000002211};
    exp_a     = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        exp_a[r*ROW_W + c*8 +: 8] = 8'(r*5 + c + 1);
    trickle[0] = 32'hABCD_EF11;
    trickle[1] = 32'h1234_5622;
    trickle[2] = 32'hFFFF_FF33;
    trickle[3] = 32'h0000_0044;

    repeat (2) tick();
    check_output("rst_busy",   LOAD_BUSY,    0);
    check_output("rst_err",    LOAD_ERR,     0);
    check_output("rst_ready",  SHADOW_READY, 0);
    check_output("rst_valid",  ACTIVE_VALID, 0);
    check_output("rst_bank",   ACTIVE_BANK,  0);
    check_output("rst_r",      ACTIVE_R,     0);
    check_output("rst_empty",  FIFO_EMPTY,   1);
    check_output("rst_full",   FIFO_FULL,    0);
    check_output("rst_ws",     WS_RD_DATA,   0);
    RESETN = 1'b1;
    tick();

    $display("[TB] 3x3 load of 1..9 then swap");
    for (int i = 1; i <= 9; i++) push_word(32'(i));
    check_output("l1_fifo_nonempty", FIFO_EMPTY, 0);
    pulse_load(4'd3, 4'd3);
    check_output("l1_busy", LOAD_BUSY, 1);
    check_output("l1_noerr", LOAD_ERR, 0);
    wait_ready(busy_cycles);
    check_output("l1_ready", SHADOW_READY, 1);
    check_output("l1_busy_cycles", 200'(busy_cycles), 9);
    check_output("l1_empty", FIFO_EMPTY, 1);
    check_output("l1_ws_before_swap", WS_RD_DATA, 0);
    check_output("l1_valid_before_swap", ACTIVE_VALID, 0);
    do_swap();
    check_output("l1_bank", ACTIVE_BANK, 1);
    check_output("l1_valid", ACTIVE_VALID, 1);
    check_output("l1_r", ACTIVE_R, 3);
    check_output("l1_s", ACTIVE_S, 3);
    check_output("l1_ready_cleared", SHADOW_READY, 0);
    check_output("l1_ws", WS_RD_DATA, exp_first);

    $display("[TB] out-of-range load requests");
    pulse_load(4'd0, 4'd3);
    check_output("err_r0_pulse", LOAD_ERR, 1);
    check_output("err_r0_busy", LOAD_BUSY, 0);
    tick();
    check_output("err_r0_pulse_end", LOAD_ERR, 0);
    pulse_load(4'd3, 4'd6);
    check_output("err_s6_pulse", LOAD_ERR, 1);
    check_output("err_s6_busy", LOAD_BUSY, 0);
    check_output("err_s6_bank", ACTIVE_BANK, 1);
    tick();
    check_output("err_s6_pulse_end", LOAD_ERR, 0);

    $display("[TB] fill FIFO to full, then clear with a push in the same cycle");
    for (int i = 0; i < 16; i++) push_word(32'h100 + 32'(i));
    check_output("fifo_full", FIFO_FULL, 1);
    push_word(32'hDEAD);
    check_output("fifo_still_full", FIFO_FULL, 1);
    CLEAR       = 1'b1;
    FIFO_WR_CMD = 1'b1;
    tick();
    CLEAR       = 1'b0;
    FIFO_WR_CMD = 1'b0;
    check_output("fifo_cleared_empty", FIFO_EMPTY, 1);
    check_output("fifo_cleared_full", FIFO_FULL, 0);

    $display("[TB] clear after 4 of 9 words");
    for (int i = 0; i < 9; i++) push_word(32'hE0 + 32'(i));
    pulse_load(4'd3, 4'd3);
    repeat (4) tick();
    check_output("clr_busy_before", LOAD_BUSY, 1);
    check_output("clr_fifo_left", FIFO_EMPTY, 0);
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    check_output("clr_empty", FIFO_EMPTY, 1);
    check_output("clr_idle", LOAD_BUSY, 0);
    check_output("clr_ready", SHADOW_READY, 0);
    check_output("clr_bank", ACTIVE_BANK, 1);
    check_output("clr_r", ACTIVE_R, 3);
    check_output("clr_ws", WS_RD_DATA, exp_first);
    tick();
    check_output("clr_ready_later", SHADOW_READY, 0);

    $display("[TB] streamed 5x5 load A");
    pulse_load(4'd5, 4'd5);
    for (int i = 0; i < 25; i++) push_word(32'(i + 1));
    wait_ready(busy_cycles);
    check_output("a_ready", SHADOW_READY, 1);
    check_output("a_empty", FIFO_EMPTY, 1);
    check_output("a_ws_before_swap", WS_RD_DATA, exp_first);
    do_swap();
    check_output("a_bank", ACTIVE_BANK, 0);
    check_output("a_r", ACTIVE_R, 5);
    check_output("a_s", ACTIVE_S, 5);
    check_output("a_ws", WS_RD_DATA, exp_a);

    $display("[TB] trickled 2x2 load B while A is in use");
    pulse_load(4'd2, 4'd2);
    check_output("b_busy_start", LOAD_BUSY, 1);
    for (int k = 0; k < 4; k++) begin
      push_word(trickle[k]);
      repeat (3) tick();
      check_output("b_fifo_drained", FIFO_EMPTY, 1);
      check_output("b_ws_holds_a", WS_RD_DATA, exp_a);
      if (k < 3) begin
        check_output("b_busy_mid", LOAD_BUSY, 1);
        check_output("b_not_ready_mid", SHADOW_READY, 0);
      end
    end
    check_output("b_ready", SHADOW_READY, 1);
    check_output("b_idle", LOAD_BUSY, 0);
    pulse_load(4'd2, 4'd2);
    check_output("b_err_while_ready", LOAD_ERR, 1);
    check_output("b_err_no_busy", LOAD_BUSY, 0);
    check_output("b_err_ready_kept", SHADOW_READY, 1);
    tick();
    do_swap();
    check_output("b_bank", ACTIVE_BANK, 1);
    check_output("b_r", ACTIVE_R, 2);
    check_output("b_s", ACTIVE_S, 2);
    check_output("b_ws", WS_RD_DATA, exp_b);

    $display("[TB] swap and load request in the same cycle");
    push_word(32'h5A);
    pulse_load(4'd1, 4'd1);
    wait_ready(busy_cycles);
    check_output("c_ready", SHADOW_READY, 1);
    PARAM_R    = 4'd1;
    PARAM_S    = 4'd1;
    SWAP       = 1'b1;
    LOAD_START = 1'b1;
    tick();
    SWAP       = 1'b0;
    LOAD_START = 1'b0;
    check_output("sl_bank", ACTIVE_BANK, 0);
    check_output("sl_busy", LOAD_BUSY, 1);
    check_output("sl_ready", SHADOW_READY, 0);
    check_output("sl_noerr", LOAD_ERR, 0);
    check_output("sl_r", ACTIVE_R, 1);
    check_output("sl_ws", WS_RD_DATA, 200'h5A);
    push_word(32'h77);
    tick();
    check_output("sl_load_ready", SHADOW_READY, 1);
    do_swap();
    check_output("sl_bank2", ACTIVE_BANK, 1);
    check_output("sl_ws2", WS_RD_DATA, 200'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
